// File: rtl/trace_capture.sv
// trace_capture: write side of the trace RAM.
// Streams qualified samples into a circular DEPTH-deep buffer. It arms once
// DEPTH - tpos_q samples of pre-trigger history exist, then stops after
// tpos_q post-trigger samples. The last address written is published as
// trace_end. The dump engine reads from trace_end+1 around the ring.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   cap_start     pulse: begin a new capture (ignored while dump_busy)
//   cap_abort     pulse: abandon the capture in progress (wins over cap_start)
//   dump_busy     dump engine active
//   smpl          sample strobe; one RAM write per strobe while capturing
//   trig          qualified trigger; only its first high cycle counts
//   trig_pos      post-trigger sample count, latched at start (0 acts as 1)
//   we            RAM write mode (PRE/ARMED/POST)
//   cap_en        RAM enable, one-cycle pulse per write
//   cap_addr      RAM write address, held between writes
//   trace_end     last address written by the most recent completed capture
//   armed         high in ARMED
//   triggered     high in POST and DONE
//   capture_done  level, set on completion, cleared by an accepted cap_start
module trace_capture #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_start,
  input  logic          cap_abort,
  input  logic          dump_busy,
  input  logic          smpl,
  input  logic          trig,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic          cap_en,
  output logic [AW-1:0] cap_addr,
  output logic [AW-1:0] trace_end,
  output logic          armed,
  output logic          triggered,
  output logic          capture_done
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] tpos_q;
  logic [AW:0]   pre_cnt;
  logic [AW:0]   post_cnt;
  logic [AW:0]   pre_tgt;
  logic          trig_q;

  logic writing;
  logic start_ok;
  logic abort_ok;
  logic trig_edge;
  logic do_write;
  logic finish;

  assign writing   = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign abort_ok  = cap_abort && writing;
  // Abort takes priority; a cap_start arriving with any cap_abort is dropped.
  assign start_ok  = cap_start && !dump_busy && !cap_abort;
  // A held trig only counts on its first high cycle.
  assign trig_edge = trig && !trig_q;
  assign do_write  = writing && smpl && !abort_ok && !start_ok;
  assign pre_tgt   = DEPTH_W - {1'b0, tpos_q};

  // Completing write: either the trigger sample itself when only one post
  // sample is wanted, or the POST write that reaches tpos_q.
  always_comb begin
    finish = 1'b0;
    if (do_write) begin
      unique case (state)
        S_ARMED: finish = trig_edge && ({1'b0, tpos_q} == ONE_W);
        S_POST:  finish = (post_cnt + ONE_W) == {1'b0, tpos_q};
        default: finish = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (abort_ok) begin
      state_nx = S_IDLE;
    end else if (start_ok) begin
      state_nx = S_PRE;
    end else begin
      unique case (state)
        S_PRE:   if (do_write && (pre_cnt + ONE_W) == pre_tgt) state_nx = S_ARMED;
        S_ARMED: if (trig_edge) state_nx = finish ? S_DONE : S_POST;
        S_POST:  if (finish) state_nx = S_DONE;
        default: state_nx = state;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    we        = writing;
    armed     = (state == S_ARMED);
    triggered = (state == S_POST) || (state == S_DONE);
  end

  // Datapath: pointers, counters and registered RAM interface
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      tpos_q       <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      trig_q       <= 1'b0;
      cap_en       <= 1'b0;
      cap_addr     <= '0;
      trace_end    <= '0;
      capture_done <= 1'b0;
    end else begin
      trig_q <= trig;
      cap_en <= do_write;
      if (start_ok) begin
        wr_ptr       <= '0;
        pre_cnt      <= '0;
        post_cnt     <= '0;
        capture_done <= 1'b0;
        tpos_q       <= (trig_pos == '0) ? AW'(1) : trig_pos;
      end else begin
        if (do_write) begin
          cap_addr <= wr_ptr;
          wr_ptr   <= wr_ptr + AW'(1);
        end
        unique case (state)
          S_PRE:   if (do_write && pre_cnt != pre_tgt) pre_cnt <= pre_cnt + ONE_W;
          S_ARMED: if (trig_edge) post_cnt <= do_write ? ONE_W : '0;
          S_POST:  if (do_write) post_cnt <= post_cnt + ONE_W;
          default: ;
        endcase
        if (finish) begin
          trace_end    <= wr_ptr;
          capture_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cap_start = 1'b0;
  logic       cap_abort = 1'b0;
  logic       dump_busy = 1'b0;
  logic       smpl = 1'b0;
  logic       trig = 1'b0;
  logic [8:0] trig_pos = '0;
  logic       we, cap_en, armed, triggered, capture_done;
  logic [8:0] cap_addr, trace_end;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  trace_capture #(.DEPTH(512), .AW(9)) dut (
    .clk(clk), .rst(rst), .cap_start(cap_start), .cap_abort(cap_abort),
    .dump_busy(dump_busy), .smpl(smpl), .trig(trig), .trig_pos(trig_pos),
    .we(we), .cap_en(cap_en), .cap_addr(cap_addr), .trace_end(trace_end),
    .armed(armed), .triggered(triggered), .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs sampled 1ns after the edge.
  task automatic step(input logic s, input logic t);
    smpl = s;
    trig = t;
    @(posedge clk);
    #1;
    smpl = 1'b0;
    trig = 1'b0;
    if (cap_en) pulses++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic start_cap(input logic [8:0] p);
    trig_pos  = p;
    cap_start = 1'b1;
    @(posedge clk);
    #1;
    cap_start = 1'b0;
    pulses = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({we, cap_en, armed, triggered, capture_done, cap_addr, trace_end}), 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    chk("idle_no_write", 32'(cap_en), 32'd0);

    // 1: trig_pos=256, 300 smpl, trig+smpl, 255 more
    start_cap(9'd256);
    chk("t1_we", 32'(we), 32'd1);
    chk("t1_cap_en_start", 32'(cap_en), 32'd0);
    step(1'b1, 1'b0);
    chk("t1_first_en", 32'(cap_en), 32'd1);
    chk("t1_first_addr", 32'(cap_addr), 32'd0);
    run(254);
    chk("t1_armed_255", 32'(armed), 32'd0);
    run(1);
    chk("t1_armed_256", 32'(armed), 32'd1);
    chk("t1_addr_255", 32'(cap_addr), 32'd255);
    run(44);
    step(1'b1, 1'b1);
    chk("t1_triggered", 32'(triggered), 32'd1);
    chk("t1_trig_addr", 32'(cap_addr), 32'd300);
    run(254);
    chk("t1_not_done", 32'(capture_done), 32'd0);
    run(1);
    chk("t1_done", 32'(capture_done), 32'd1);
    chk("t1_trace_end", 32'(trace_end), 32'd43);
    chk("t1_pulses", 32'(pulses), 32'd556);
    chk("t1_trig_done", 32'(triggered), 32'd1);
    step(1'b1, 1'b0);
    chk("t1_done_no_write", 32'({we, cap_en}), 32'd0);

    // 2: trig_pos=100, wrap, sample gaps in POST
    start_cap(9'd100);
    chk("t2_done_cleared", 32'(capture_done), 32'd0);
    run(512);
    chk("t2_addr_511", 32'(cap_addr), 32'd511);
    run(1);
    chk("t2_wrap_0", 32'(cap_addr), 32'd0);
    chk("t2_armed", 32'(armed), 32'd1);
    run(187);
    step(1'b1, 1'b1);
    chk("t2_trig_addr", 32'(cap_addr), 32'd188);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t2_gap_no_en", 32'(cap_en), 32'd0);
    chk("t2_gap_addr_hold", 32'(cap_addr), 32'd188);
    chk("t2_gap_state", 32'({triggered, capture_done}), 32'b10);
    run(98);
    chk("t2_not_done", 32'(capture_done), 32'd0);
    run(1);
    chk("t2_done", 32'(capture_done), 32'd1);
    chk("t2_trace_end", 32'(trace_end), 32'd287);

    // 3: trig in PRE ignored, trig without smpl in ARMED
    start_cap(9'd256);
    run(10);
    step(1'b1, 1'b1);
    chk("t3_pre_trig_ign", 32'({armed, triggered}), 32'd0);
    run(244);
    chk("t3_armed_255", 32'(armed), 32'd0);
    run(1);
    chk("t3_armed_256", 32'(armed), 32'd1);
    step(1'b0, 1'b1);
    chk("t3_trig_nosmpl", 32'({triggered, cap_en}), 32'b10);
    run(255);
    chk("t3_not_done", 32'(capture_done), 32'd0);
    run(1);
    chk("t3_done", 32'(capture_done), 32'd1);
    chk("t3_trace_end", 32'(trace_end), 32'd511);

    // 5: cap_start ignored while dump_busy
    dump_busy = 1'b1;
    start_cap(9'd5);
    chk("t5_done_kept", 32'(capture_done), 32'd1);
    chk("t5_we", 32'(we), 32'd0);
    step(1'b1, 1'b0);
    chk("t5_no_en", 32'(cap_en), 32'd0);
    dump_busy = 1'b0;

    // 4: trig_pos=0 behaves as 1
    start_cap(9'd0);
    run(510);
    chk("t4_armed_510", 32'(armed), 32'd0);
    run(1);
    chk("t4_armed_511", 32'(armed), 32'd1);
    run(5);
    step(1'b1, 1'b1);
    chk("t4_done", 32'(capture_done), 32'd1);
    chk("t4_trace_end", 32'(trace_end), 32'd4);
    chk("t4_addr", 32'(cap_addr), 32'd4);

    // abort in DONE ignored
    cap_abort = 1'b1;
    step(1'b0, 1'b0);
    cap_abort = 1'b0;
    chk("abort_done_ign", 32'({triggered, capture_done}), 32'b11);

    // restart while capturing, then abort together with start
    start_cap(9'd256);
    run(20);
    start_cap(9'd256);
    step(1'b1, 1'b0);
    chk("restart_addr", 32'(cap_addr), 32'd0);
    cap_abort = 1'b1;
    cap_start = 1'b1;
    step(1'b1, 1'b0);
    cap_abort = 1'b0;
    cap_start = 1'b0;
    chk("abort_wins", 32'({we, cap_en}), 32'd0);
    chk("abort_wins_end", 32'(trace_end), 32'd4);

    // 6a: abort in POST
    start_cap(9'd256);
    run(256);
    step(1'b1, 1'b1);
    run(50);
    cap_abort = 1'b1;
    step(1'b1, 1'b0);
    cap_abort = 1'b0;
    chk("t6a_idle", 32'({we, cap_en, triggered}), 32'd0);
    chk("t6a_trace_end", 32'(trace_end), 32'd4);
    chk("t6a_done", 32'(capture_done), 32'd0);
    pulses = 0;
    run(3);
    chk("t6a_no_writes", 32'(pulses), 32'd0);

    // 6b: asynchronous reset in POST
    start_cap(9'd256);
    run(256);
    step(1'b1, 1'b1);
    run(50);
    chk("t6b_pre_rst", 32'(triggered), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6b_async_rst", 32'({we, cap_en, armed, triggered, capture_done, cap_addr, trace_end}), 32'd0);
    #2;
    rst = 1'b0;
    pulses = 0;
    run(3);
    chk("t6b_no_writes", 32'({pulses[3:0], we}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
